obi_mem_arbiter: RTL and testbench

//  Two-requester OBI arbiter sharing one data-memory port between instruction fetch (m0) and the MEM stage (m1).

---
 rtl/obi_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-requester OBI arbiter (fetch m0, MEM m1) onto one shared memory port, with in-order response routing.
// Build option: OBI_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise m1 has fixed priority over m0.
module obi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,
    output logic                    s_req_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    input  logic                    s_err_i,
    output logic                    unexp_rsp_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ARB_FREE    = 2'd0,
        ARB_HELD_M0 = 2'd1,
        ARB_HELD_M1 = 2'd2
    } arb_state_e;

    arb_state_e                 state_q, state_d;
    logic                       sel_m1;
    logic                       sel_req;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       head_m1;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       unexp_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Tie-break preference: set means m1 wins the next simultaneous request.
    logic rr_m1_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_m1_q <= 1'b0;
        end else if (push) begin
            rr_m1_q <= ~sel_m1;
        end
    end
`endif

    // Lock state register: holds the presented requester while the address phase is ungranted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        sel_m1  = 1'b0;
        sel_req = 1'b0;
        state_d = state_q;
        case (state_q)
            ARB_HELD_M0: begin
                sel_m1  = 1'b0;
                sel_req = m0_req_i;
            end
            ARB_HELD_M1: begin
                sel_m1  = 1'b1;
                sel_req = m1_req_i;
            end
            default: begin
                sel_req = m0_req_i | m1_req_i;
`ifdef OBI_ARB_ROUND_ROBIN_EN
                sel_m1  = (m0_req_i & m1_req_i) ? rr_m1_q : m1_req_i;
`else
                sel_m1  = m1_req_i;
`endif
            end
        endcase
        if (sel_req && !fifo_full) begin
            if (s_gnt_i) begin
                state_d = ARB_FREE;
            end else begin
                state_d = sel_m1 ? ARB_HELD_M1 : ARB_HELD_M0;
            end
        end
    end

    // Address phase: full FIFO is judged on registered occupancy so a same-cycle pop never feeds gnt.
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign s_req_o    = sel_req & ~fifo_full;
    assign s_addr_o   = sel_m1 ? m1_addr_i : m0_addr_i;
    assign s_we_o     = sel_m1 & m1_we_i;
    assign s_wdata_o  = sel_m1 ? m1_wdata_i : '0;
    assign s_be_o     = sel_m1 ? m1_be_i : {BE_W{1'b1}};
    assign push       = s_req_o & s_gnt_i;
    assign m0_gnt_o   = push & ~sel_m1;
    assign m1_gnt_o   = push & sel_m1;

    // Response phase: steer to the oldest outstanding owner; stray responses are dropped.
    assign pop         = s_rvalid_i & ~fifo_empty;
    assign head_m1     = owner_q[rd_ptr_q];
    assign m0_rvalid_o = pop & ~head_m1;
    assign m1_rvalid_o = pop & head_m1;
    assign m0_err_o    = pop & ~head_m1 & s_err_i;
    assign m1_err_o    = pop & head_m1 & s_err_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign unexp_rsp_o = unexp_q;

    // Owner FIFO and sticky stray-response flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel_m1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (s_rvalid_i && fifo_empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_obi_mem_arbiter;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        m0_req_i, m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_addr_i, m0_rdata_o;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_be_i;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, s_err_i, unexp_rsp_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;

    obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .s_err_i(s_err_i), .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];
    int   own_q[$];     // owners of accepted, unanswered transactions, oldest first
    int   held  = -1;   // requester whose ungranted address phase must stay presented
    int   pref  = 0;    // round-robin: requester that wins a tie
    logic unexp_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: whenever a requester sees a response, compare it with the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_rvalid_o === 1'b1 || m1_rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_expectation", 64'(1), 64'(0));
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_m0_rvalid", 64'(m0_rvalid_o), 64'(e.owner == 0));
                    check("rsp_m1_rvalid", 64'(m1_rvalid_o), 64'(e.owner == 1));
                    check("rsp_m0_err", 64'(m0_err_o), 64'(e.owner == 0 && e.err));
                    check("rsp_m1_err", 64'(m1_err_o), 64'(e.owner == 1 && e.err));
                    check("rsp_m0_rdata", 64'(m0_rdata_o), 64'(e.data));
                    check("rsp_m1_rdata", 64'(m1_rdata_o), 64'(e.data));
                end
            end
        end
    end

    // One clock of stimulus; the model predicts the address phase and commits its state afterwards.
    task automatic cycle(input logic r0, input logic [31:0] a0,
                         input logic r1, input logic [31:0] a1, input logic we,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic gnt, input logic rv, input logic [31:0] rd, input logic er,
                         output logic g0, output logic g1);
        int   sel;
        logic sel_req, sreq, rsp;
        rsp_t e;
        @(posedge clk); #1;
        m0_req_i = r0; m0_addr_i = a0;
        m1_req_i = r1; m1_addr_i = a1; m1_we_i = we; m1_wdata_i = wd; m1_be_i = be;
        s_gnt_i = gnt; s_rvalid_i = rv; s_rdata_i = rd; s_err_i = er;
        if (held >= 0) begin
            sel     = held;
            sel_req = (held == 0) ? r0 : r1;
        end else begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            sel = (r0 && r1) ? pref : (r1 ? 1 : 0);
`else
            sel = r1 ? 1 : 0;
`endif
            sel_req = r0 | r1;
        end
        sreq = sel_req && (own_q.size() < MAX);
        rsp  = rv && (own_q.size() > 0);
        if (rsp) begin
            e.owner = own_q[0]; e.data = rd; e.err = er;
            exp_q.push_back(e);
        end
        g0 = sreq && gnt && sel == 0;
        g1 = sreq && gnt && sel == 1;
        @(negedge clk);
        check("s_req", 64'(s_req_o), 64'(sreq));
        check("m0_gnt", 64'(m0_gnt_o), 64'(g0));
        check("m1_gnt", 64'(m1_gnt_o), 64'(g1));
        check("any_rvalid", 64'(m0_rvalid_o | m1_rvalid_o), 64'(rsp));
        check("unexp_rsp", 64'(unexp_rsp_o), 64'(unexp_m));
        if (sreq) begin
            check("s_addr", 64'(s_addr_o), 64'(sel == 1 ? a1 : a0));
            check("s_we", 64'(s_we_o), 64'(sel == 1 ? we : 1'b0));
            check("s_be", 64'(s_be_o), 64'(sel == 1 ? be : 4'hF));
            if (sel == 1) check("s_wdata", 64'(s_wdata_o), 64'(wd));
        end
        if (rv && own_q.size() == 0) unexp_m = 1'b1;
        if (rsp) void'(own_q.pop_front());
        if (sreq && gnt) begin
            own_q.push_back(sel);
            held = -1;
            pref = 1 - sel;
        end else if (sreq) begin
            held = sel;
        end
    endtask

    task automatic idle(input logic rv, input logic [31:0] rd, input logic er);
        logic g0, g1;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, rv, rd, er, g0, g1);
    endtask

    task automatic drain();
        for (int i = 0; i < MAX + 2; i++) begin
            if (own_q.size() > 0) idle(1'b1, $urandom, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn_i = 1'b0;
        m0_req_i = 0; m0_addr_i = 0; m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0;
        m1_wdata_i = 0; m1_be_i = 0; s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0; s_err_i = 0;
        own_q.delete(); held = -1; pref = 0; unexp_m = 1'b0;
        @(negedge clk);
        check("rst_s_req", 64'(s_req_o), 64'(0));
        check("rst_gnt", 64'({m0_gnt_o, m1_gnt_o}), 64'(0));
        check("rst_rvalid", 64'({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}), 64'(0));
        check("rst_unexp", 64'(unexp_rsp_o), 64'(0));
        @(posedge clk); #1;
        rstn_i = 1'b1;
    endtask

    logic        g0, g1, p0, p1, w1;
    logic [31:0] pa0, pa1, pd1;
    logic [3:0]  pb1;

    initial begin
        rstn_i = 1'b0;
        do_reset();
        idle(1'b0, 32'h0, 1'b0);

        // Single read from fetch
        cycle(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        idle(1'b1, 32'hDEADBEEF, 1'b0);

        // Contention over three grants, responses returned meanwhile
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h200 + 32'(i), 1, 32'h300 + 32'(i), 0, 0, 4'hF, 1, (i > 0), 32'hC0DE0000 + 32'(i), 0, g0, g1);
        drain();

        // Lock: m0 presented, ungranted while m1 joins
        cycle(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 2; i++) cycle(1, 32'h400, 1, 32'h500, 1, 32'h55, 4'h3, 0, 0, 0, 0, g0, g1);
        cycle(1, 32'h400, 1, 32'h500, 1, 32'h55, 4'h3, 1, 0, 0, 0, g0, g1);
        check("lock_m0_granted", 64'(g0), 64'(1));
        cycle(0, 0, 1, 32'h500, 1, 32'h55, 4'h3, 1, 0, 0, 0, g0, g1);
        drain();

        // Full: two grants, stall, pop without same-cycle unblock, then resume
        cycle(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        cycle(1, 32'h604, 0, 0, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        cycle(0, 0, 1, 32'h700, 0, 0, 4'hF, 1, 0, 0, 0, g0, g1);
        cycle(0, 0, 1, 32'h700, 0, 0, 4'hF, 1, 1, 32'h11111111, 0, g0, g1);
        cycle(0, 0, 1, 32'h700, 0, 0, 4'hF, 1, 0, 0, 0, g0, g1);
        check("full_resume_m1", 64'(g1), 64'(1));
        drain();

        // Interleave: m1 write then m0 read; error on the first response
        cycle(0, 0, 1, 32'h800, 1, 32'hA5A5A5A5, 4'h5, 1, 0, 0, 0, g0, g1);
        cycle(1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        idle(1'b1, 32'hBAD0BAD0, 1'b1);
        idle(1'b1, 32'h12345678, 1'b0);

        // Random traffic with OBI-compliant requesters
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd1 = 0; pb1 = 0; w1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && ($urandom % 2 == 0)) begin p0 = 1; pa0 = $urandom & 32'hFFFC; end
            if (!p1 && ($urandom % 2 == 0)) begin
                p1 = 1; pa1 = $urandom & 32'hFFFC; w1 = 1'($urandom); pd1 = $urandom; pb1 = 4'($urandom);
            end
            cycle(p0, pa0, p1, pa1, w1, pd1, pb1, ($urandom % 4 != 0),
                  (own_q.size() > 0) && ($urandom % 2 == 0), $urandom, ($urandom % 8 == 0), g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        // Hold any pending request until accepted, then drain
        for (int n = 0; n < 8 && (p0 || p1); n++) begin
            cycle(p0, pa0, p1, pa1, w1, pd1, pb1, 1, (own_q.size() > 0), $urandom, 0, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        drain();

        // Stray response with empty FIFO: dropped, sticky flag
        idle(1'b1, 32'hFFFFFFFF, 1'b0);
        idle(1'b0, 32'h0, 1'b0);
        check("unexp_sticky", 64'(unexp_rsp_o), 64'(1));

        // Reset mid-transaction flushes the FIFO; late response is stray
        do_reset();
        cycle(1, 32'hA00, 0, 0, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        do_reset();
        idle(1'b1, 32'h0BADF00D, 1'b0);
        idle(1'b0, 32'h0, 1'b0);
        check("unexp_after_flush", 64'(unexp_rsp_o), 64'(1));
        do_reset();
        idle(1'b0, 32'h0, 1'b0);

        @(negedge clk);
        check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
